saph_pixread_responder: RTL and testbench

- MEM-side responder for the Sapphire pixel-lookup port.
- Accepts (x, y) lookups from the GPU and converts each to a framebuffer word address.
- Issues single-word reads to a fixed-latency memory and returns the pixel colour exactly LATENCY cycles after the accepted trigger.
- Out-of-bounds coordinates return a configurable border colour without touching memory.
- Full throughput: one lookup per cycle.

---
 rtl/saph_defines.sv | 10 +
 rtl/saph_pixread_responder_if.sv | 13 +
 rtl/saph_pixread_responder.sv | 147 ++++++++++++++
 tb/tb_saph_pixread_responder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/saph_defines.sv
// Shared Sapphire type definitions: the packed RGB565 pixel colour.
package saph_defines;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } color;

endpackage

// File: rtl/saph_pixread_responder_if.sv
// Sapphire pixel-lookup port: the GPU issues (x, y) lookups and receives the colour.
interface saph_pixread_responder_if;
  import saph_defines::*;

  logic        d_trig;
  logic [13:0] d_x;
  logic [13:0] d_y;
  logic        d_ready;
  color        q_res;

  modport master (output d_trig, d_x, d_y, input d_ready, q_res);
  modport slave  (input d_trig, d_x, d_y, output d_ready, q_res);
endinterface

// File: rtl/saph_pixread_responder.sv
// MEM-side pixel lookup responder: (x, y) -> word read -> colour after exactly LATENCY cycles.
// Optional single-entry last-pixel cache enabled by defining SAPH_PIXREAD_CACHE_EN.
module saph_pixread_responder
  import saph_defines::*;
#(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  saph_pixread_responder_if.slave pix,
  input  logic [ADDR_W-1:0]       cfg_base,
  input  logic [15:0]             cfg_stride,
  input  logic [13:0]             cfg_width,
  input  logic [13:0]             cfg_height,
  input  color                    cfg_border,
  input  logic                    mem_ready,
  output logic                    mem_re,
  output logic [ADDR_W-1:0]       mem_addr,
  input  color                    mem_rdata
);

  localparam int unsigned DLY = LATENCY - MEM_LAT - 1;

  if (LATENCY < MEM_LAT + 2) begin : g_latency_check
    $error("saph_pixread_responder: LATENCY must be at least MEM_LAT+2");
  end

  typedef enum logic [1:0] {SRC_MEM, SRC_BORDER, SRC_CACHE} src_e;

  typedef struct packed {
    src_e src;
    color colour;
  } slot_t;

  logic              accept;
  logic              oob;
  logic              hit;
  logic              issue;
  logic [ADDR_W-1:0] addr_calc;
  src_e              new_src;
  color              cap_colour;

  // pv/ps: slot from the accept edge up to the data-capture edge
  logic [MEM_LAT:0]  pv;
  slot_t             ps [MEM_LAT+1];
  // dv/dd: captured colours waiting for their q_res edge
  logic [DLY-1:0]    dv;
  color              dd [DLY];

  assign pix.d_ready = mem_ready & rst_n;
  assign accept      = pix.d_trig & pix.d_ready;

  always_comb begin
    oob       = (pix.d_x >= cfg_width) | (pix.d_y >= cfg_height);
    addr_calc = cfg_base + ADDR_W'(pix.d_y) * ADDR_W'(cfg_stride) + ADDR_W'(pix.d_x);
  end

`ifdef SAPH_PIXREAD_CACHE_EN
  logic              tag_valid;
  logic [ADDR_W-1:0] tag_addr;
  logic [ADDR_W-1:0] base_q;
  logic [15:0]       stride_q;
  logic              cfg_changed;
  color              cache_colour;

  assign cfg_changed = (cfg_base != base_q) | (cfg_stride != stride_q);
  assign hit         = tag_valid & ~cfg_changed & (tag_addr == addr_calc);

  // The tag follows the most recently issued read; its data lands in cache_colour before
  // any later hit reaches capture, which gives in-flight forwarding for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid <= 1'b0;
      tag_addr  <= '0;
      base_q    <= '0;
      stride_q  <= '0;
    end else begin
      if (accept) begin
        base_q   <= cfg_base;
        stride_q <= cfg_stride;
      end
      if (issue) begin
        tag_valid <= 1'b1;
        tag_addr  <= addr_calc;
      end else if (cfg_changed) begin
        tag_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pv[MEM_LAT] && (ps[MEM_LAT].src == SRC_MEM)) cache_colour <= mem_rdata;
  end
`else
  assign hit = 1'b0;
`endif

  assign issue = accept & ~oob & ~hit;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    new_src = SRC_MEM;
    if (oob)      new_src = SRC_BORDER;
    else if (hit) new_src = SRC_CACHE;
  end

  always_comb begin
    cap_colour = ps[MEM_LAT].colour;
    case (ps[MEM_LAT].src)
      SRC_MEM:   cap_colour = mem_rdata;
`ifdef SAPH_PIXREAD_CACHE_EN
      SRC_CACHE: cap_colour = cache_colour;
`endif
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv        <= '0;
      dv        <= '0;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
      pix.q_res <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
      pv[0] <= accept;
      for (int i = 1; i <= int'(MEM_LAT); i++) pv[i] <= pv[i-1];
      dv[0] <= pv[MEM_LAT];
      for (int i = 1; i < int'(DLY); i++) dv[i] <= dv[i-1];
      mem_re <= issue;
      if (issue)      mem_addr  <= addr_calc;
      if (dv[DLY-1])  pix.q_res <= dd[DLY-1];
    end
  end

  // NOTE: payload lanes carry no reset; only the valid bits above decide what reaches q_res.
  always_ff @(posedge clk) begin
    ps[0] <= '{src: new_src, colour: cfg_border};
    for (int i = 1; i <= int'(MEM_LAT); i++) ps[i] <= ps[i-1];
    dd[0] <= cap_colour;
    for (int i = 1; i < int'(DLY); i++) dd[i] <= dd[i-1];
  end

endmodule

// File: tb/tb_saph_pixread_responder.sv
// Scoreboard bench for saph_pixread_responder: a reference model queues expected reads and
// results at stimulus time, a monitor compares them against the DUT every cycle.
module tb_saph_pixread_responder;
  import saph_defines::*;

  localparam int unsigned LATENCY = 4;
  localparam int unsigned MEM_LAT = 2;
  localparam int unsigned ADDR_W  = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cfg_base;
  logic [15:0] cfg_stride;
  logic [13:0] cfg_width;
  logic [13:0] cfg_height;
  color        cfg_border;
  logic        mem_ready;
  logic        mem_re;
  logic [31:0] mem_addr;
  color        mem_rdata = '0;

  saph_pixread_responder_if pif ();

  saph_pixread_responder #(
    .LATENCY(LATENCY), .MEM_LAT(MEM_LAT), .ADDR_W(ADDR_W)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix        (pif),
    .cfg_base   (cfg_base),
    .cfg_stride (cfg_stride),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .cfg_border (cfg_border),
    .mem_ready  (mem_ready),
    .mem_re     (mem_re),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata)
  );

  typedef struct { int unsigned due; color c; } res_t;
  typedef struct { int unsigned due; logic [31:0] addr; } rd_t;

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  int unsigned reads_seen = 0;
  color        prev_q   = '0;
  res_t        res_q[$];
  rd_t         rd_q[$];
  color        slot_d [16];
  bit          slot_v [16];
  bit          c_valid  = 1'b0;
  logic [31:0] c_addr   = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic color mem_fn(logic [31:0] a);
    logic [15:0] v;
    v = a[15:0] ^ a[31:16] ^ {a[7:0], a[15:8]} ^ 16'h5A3C;
    return color'(v);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Memory: a read seen in cycle n returns data in cycle n+MEM_LAT, garbage otherwise.
  always @(negedge clk) begin
    if (mem_re === 1'b1) begin
      slot_v[(cyc + MEM_LAT) % 16] <= 1'b1;
      slot_d[(cyc + MEM_LAT) % 16] <= mem_fn(mem_addr);
      reads_seen <= reads_seen + 1;
    end
    mem_rdata        <= slot_v[cyc % 16] ? slot_d[cyc % 16] : color'(16'($urandom));
    slot_v[cyc % 16] <= 1'b0;
  end

  // Monitor: pop expectations when due, otherwise require idle / held outputs.
  always @(negedge clk) begin
    check("d_ready", pif.d_ready, mem_ready & rst_n);
    if (!rst_n) begin
      check("rst_mem_re", mem_re, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_q_res", pif.q_res, 0);
      prev_q <= '0;
    end else begin
      if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
        check("mem_re", mem_re, 1);
        check("mem_addr", mem_addr, rd_q[0].addr);
        void'(rd_q.pop_front());
      end else begin
        check("mem_re_idle", mem_re, 0);
      end
      if (res_q.size() > 0 && res_q[0].due == cyc) begin
        check("q_res", pif.q_res, res_q[0].c);
        prev_q <= res_q[0].c;
        void'(res_q.pop_front());
      end else begin
        check("q_res_hold", pif.q_res, prev_q);
      end
    end
  end

  function automatic void model_accept(logic [13:0] x, logic [13:0] y);
    int unsigned     t;
    longint unsigned b, s, full;
    logic [31:0]     a;
    bit              hit;
    t    = cyc + 1;
    b    = cfg_base;
    s    = cfg_stride;
    full = b + longint'(y) * s + longint'(x);
    a    = full[31:0];
    hit  = 1'b0;
    if (x >= cfg_width || y >= cfg_height) begin
      res_q.push_back('{t + LATENCY, cfg_border});
    end else begin
`ifdef SAPH_PIXREAD_CACHE_EN
      hit = c_valid && (c_addr == a);
      if (!hit) begin
        c_valid = 1'b1;
        c_addr  = a;
      end
`endif
      if (!hit) rd_q.push_back('{t, a});
      res_q.push_back('{t + LATENCY, mem_fn(a)});
    end
  endfunction

  function automatic void model_reset();
    res_q.delete();
    rd_q.delete();
    c_valid = 1'b0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input bit trig, input logic [13:0] x, input logic [13:0] y);
    pif.d_trig = trig;
    pif.d_x    = x;
    pif.d_y    = y;
    if (trig && mem_ready && rst_n) model_accept(x, y);
    step();
    pif.d_trig = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) lookup(1'b0, 14'd0, 14'd0);
  endtask

  task automatic set_cfg(input logic [31:0] b, input logic [15:0] s,
                         input logic [13:0] w, input logic [13:0] h, input color brd);
    if (b != cfg_base || s != cfg_stride) c_valid = 1'b0;
    cfg_base   = b;
    cfg_stride = s;
    cfg_width  = w;
    cfg_height = h;
    cfg_border = brd;
  endtask

  task automatic random_phase(input int n);
    logic [13:0] last_x, last_y;
    last_x = 14'd0;
    last_y = 14'd0;
    for (int i = 0; i < n; i++) begin
      logic [13:0] x, y;
      int unsigned r, w, h;
      w = cfg_width;
      h = cfg_height;
      mem_ready = ($urandom_range(0, 9) < 8);
      r = $urandom_range(0, 9);
      x = 14'($urandom);
      y = 14'($urandom);
      if (w > 0 && h > 0) begin
        if (r < 6) begin
          x = 14'($urandom_range(0, w - 1));
          y = 14'($urandom_range(0, h - 1));
        end else if (r == 6) begin
          x = 14'(w - 1);
          y = 14'(h - 1);
        end else if (r == 7) begin
          x = 14'(w);
          y = 14'($urandom_range(0, h - 1));
        end else if (r == 8) begin
          x = 14'($urandom_range(0, w - 1));
          y = 14'(h);
        end else begin
          x = last_x;
          y = last_y;
        end
      end
      lookup($urandom_range(0, 9) < 7, x, y);
      last_x = x;
      last_y = y;
    end
  endtask

  initial begin
    int unsigned r0;
    rst_n      = 1'b0;
    mem_ready  = 1'b0;
    pif.d_trig = 1'b0;
    pif.d_x    = '0;
    pif.d_y    = '0;
    cfg_base   = '0;
    cfg_stride = '0;
    cfg_width  = '0;
    cfg_height = '0;
    cfg_border = '0;
    repeat (3) step();
    rst_n = 1'b1;

    // Single in-bounds lookup, then the two out-of-bounds edges.
    set_cfg(32'h1000, 16'd320, 14'd320, 14'd240, color'(16'hF800));
    mem_ready = 1'b1;
    lookup(1'b1, 14'd5, 14'd2);
    idle(6);
    lookup(1'b1, 14'd320, 14'd0);
    lookup(1'b1, 14'd0, 14'd240);
    idle(6);

    // Not ready: trigger must be ignored.
    mem_ready = 1'b0;
    lookup(1'b1, 14'd10, 14'd10);
    idle(8);
    mem_ready = 1'b1;

    // Back-to-back interleaved memory / border lookups, including the far corner.
    lookup(1'b1, 14'd1, 14'd1);
    lookup(1'b1, 14'd400, 14'd1);
    lookup(1'b1, 14'd319, 14'd239);
    lookup(1'b1, 14'd0, 14'd300);
    idle(6);

    // Reset while a lookup is in flight: no late update after release.
    lookup(1'b1, 14'd7, 14'd7);
    idle(1);
    rst_n = 1'b0;
    model_reset();
    step();
    rst_n = 1'b1;
    idle(8);

`ifdef SAPH_PIXREAD_CACHE_EN
    r0 = reads_seen;
    lookup(1'b1, 14'd5, 14'd2);
    lookup(1'b1, 14'd5, 14'd2);
    idle(6);
    check("cache_one_read", reads_seen - r0, 1);
`else
    r0 = 0;
`endif

    random_phase(300);
    set_cfg(32'hFFFF_FF00, 16'd1024, 14'd100, 14'd50, color'(16'h07E0));
    random_phase(200);
    set_cfg(32'h2000, 16'd64, 14'd0, 14'd20, color'(16'h001F));
    random_phase(50);
    set_cfg(32'h40, 16'd8, 14'd16, 14'd16, color'(16'hFFFF));
    random_phase(200);
    mem_ready = 1'b1;
    idle(LATENCY + MEM_LAT + 4);

    check("res_drained", res_q.size(), 0);
    check("rd_drained", rd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
